// File: rtl/iconn_pkg.sv
// Shared definitions for the 2x2 interconnect node: port index type,
// port count and the destination-port extraction helper.
package iconn_pkg;

  localparam int ICONN_PORT_NUM = 2;

  typedef logic iconn_port_sel_t;

  function automatic iconn_port_sel_t dst_port(input logic [31:0] addr,
                                               input logic [4:0]  bit_id);
    return addr[bit_id];
  endfunction

endpackage

// File: rtl/iconn_port_fifo.sv
// Per-input-port register-array FIFO. Head entry is shown raw; busy_o
// flags a valid head. A full FIFO refuses pushes even when popping.
module iconn_port_fifo #(
  parameter int NODE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH      = 64,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid_i,
  input  logic [NODE_ADDR_WIDTH-1:0] push_addr_i,
  input  logic [DATA_WIDTH-1:0]      push_data_i,
  output logic                       push_ready_o,
  input  logic                       pop_i,
  output logic                       busy_o,
  output logic [NODE_ADDR_WIDTH-1:0] head_addr_o,
  output logic [DATA_WIDTH-1:0]      head_data_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NODE_ADDR_WIDTH-1:0] addrMem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]      dataMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]           wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]           rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       push, pop;

  assign push_ready_o = (count_q != CNT_W'(FIFO_DEPTH));
  assign busy_o       = (count_q != '0);
  assign push         = push_valid_i & push_ready_o;
  assign pop          = pop_i & busy_o;
  assign head_addr_o  = addrMem_q[rdPtr_q];
  assign head_data_o  = dataMem_q[rdPtr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + 1'b1;
    if (pop)  rdPtr_d = rdPtr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addrMem_q[i] <= '0;
        dataMem_q[i] <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (push) begin
        addrMem_q[wrPtr_q] <= push_addr_i;
        dataMem_q[wrPtr_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/iconn_node_ingress.sv
// Ingress buffering and output-conflict arbitration for one 2x2 node:
// never presents two heads that target the same mux output.
module iconn_node_ingress
  import iconn_pkg::*;
#(
  parameter int NODE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_BIT_ID     = 0,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [ICONN_PORT_NUM-1:0][NODE_ADDR_WIDTH-1:0] in_addr,
  input  logic [ICONN_PORT_NUM-1:0][DATA_WIDTH-1:0]      in_data,
  input  logic [ICONN_PORT_NUM-1:0]                      in_valid,
  output logic [ICONN_PORT_NUM-1:0]                      in_ready,
  output logic [ICONN_PORT_NUM-1:0][NODE_ADDR_WIDTH-1:0] ain,
  output logic [ICONN_PORT_NUM-1:0][DATA_WIDTH-1:0]      din,
  output logic [ICONN_PORT_NUM-1:0]                      din_valid,
  input  logic [ICONN_PORT_NUM-1:0]                      out_ready
);

  logic [ICONN_PORT_NUM-1:0] busy;
  logic [ICONN_PORT_NUM-1:0] dst;
  logic [ICONN_PORT_NUM-1:0] pop;
  logic                      conflict;
  iconn_port_sel_t           rr_q, rr_d;

  for (genvar g = 0; g < ICONN_PORT_NUM; g++) begin : g_fifo
    iconn_port_fifo #(
      .NODE_ADDR_WIDTH (NODE_ADDR_WIDTH),
      .DATA_WIDTH      (DATA_WIDTH),
      .FIFO_DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_valid_i (in_valid[g]),
      .push_addr_i  (in_addr[g]),
      .push_data_i  (in_data[g]),
      .push_ready_o (in_ready[g]),
      .pop_i        (pop[g]),
      .busy_o       (busy[g]),
      .head_addr_o  (ain[g]),
      .head_data_o  (din[g])
    );
  end

  // On a shared destination only the round-robin winner is shown.
  always_comb begin
    for (int p = 0; p < ICONN_PORT_NUM; p++)
      dst[p] = dst_port(32'(ain[p]), 5'(ADDR_BIT_ID));
    conflict     = busy[0] & busy[1] & (dst[0] == dst[1]);
    din_valid[0] = busy[0] & (!conflict | (rr_q == 1'b0));
    din_valid[1] = busy[1] & (!conflict | (rr_q == 1'b1));
    for (int p = 0; p < ICONN_PORT_NUM; p++)
      pop[p] = din_valid[p] & out_ready[dst[p]];
  end

  // Priority only moves once the conflict winner actually leaves.
  always_comb begin
    rr_d = rr_q;
    if (conflict && pop[rr_q]) rr_d = ~rr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end

endmodule

// File: tb/tb_iconn_node_ingress.sv
// Directed plus randomized bench for iconn_node_ingress, checked against a
// queue-based model of the buffering and fair arbitration rules.
module tb_iconn_node_ingress;

  localparam int NA    = 5;
  localparam int DW    = 64;
  localparam int BITID = 0;
  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0][NA-1:0]    inAddr;
  logic [1:0][DW-1:0]    inData;
  logic [1:0]            inValid;
  logic [1:0]            inReady;
  logic [1:0][NA-1:0]    ain;
  logic [1:0][DW-1:0]    din;
  logic [1:0]            dinValid;
  logic [1:0]            outReady;

  typedef struct packed {
    logic [NA-1:0] addr;
    logic [DW-1:0] data;
  } pkt_t;

  pkt_t        q0[$];
  pkt_t        q1[$];
  bit          rrModel;
  int          checks = 0;
  int          errors = 0;
  bit          logT6 = 1'b0;
  logic [DW-1:0] t6Log[$];

  iconn_node_ingress #(
    .NODE_ADDR_WIDTH (NA),
    .DATA_WIDTH      (DW),
    .ADDR_BIT_ID     (BITID),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_addr   (inAddr),
    .in_data   (inData),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .ain       (ain),
    .din       (din),
    .din_valid (dinValid),
    .out_ready (outReady)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Which heads the model says may be offered to the mux this cycle.
  function automatic logic [1:0] expPresent();
    logic [1:0] pres;
    pres = {q1.size() != 0, q0.size() != 0};
    if (pres == 2'b11 && q0[0].addr[BITID] == q1[0].addr[BITID])
      pres = rrModel ? 2'b10 : 2'b01;
    return pres;
  endfunction

  task automatic checkOutput(input string tag);
    cmp({tag, ".din_valid"}, 64'(dinValid), 64'(expPresent()));
    cmp({tag, ".in_ready"}, 64'(inReady), 64'({q1.size() != DEPTH, q0.size() != DEPTH}));
    if (q0.size() != 0) begin
      cmp({tag, ".ain0"}, 64'(ain[0]), 64'(q0[0].addr));
      cmp({tag, ".din0"}, din[0], q0[0].data);
    end
    if (q1.size() != 0) begin
      cmp({tag, ".ain1"}, 64'(ain[1]), 64'(q1[0].addr));
      cmp({tag, ".din1"}, din[1], q1[0].data);
    end
  endtask

  // Drive one cycle of inputs, check current outputs, advance the model
  // across the next rising edge.
  task automatic applyStimulus(input logic [1:0] v, input logic [NA-1:0] a0, input logic [NA-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic [1:0] ordy, input string tag);
    logic [1:0] pres, acc;
    bit pop0, pop1, clash;
    inValid = v; inAddr[0] = a0; inAddr[1] = a1;
    inData[0] = d0; inData[1] = d1; outReady = ordy;
    checkOutput(tag);
    if (logT6 && dinValid[1] && outReady[ain[1][BITID]]) t6Log.push_back(din[1]);
    pres  = expPresent();
    acc   = {q1.size() != DEPTH, q0.size() != DEPTH};
    clash = q0.size() != 0 && q1.size() != 0 && q0[0].addr[BITID] == q1[0].addr[BITID];
    pop0  = pres[0] && ordy[q0[0].addr[BITID]];
    pop1  = pres[1] && ordy[q1[0].addr[BITID]];
    if (clash && (rrModel ? pop1 : pop0)) rrModel = ~rrModel;
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (v[0] && acc[0]) q0.push_back('{addr: a0, data: d0});
    if (v[1] && acc[1]) q1.push_back('{addr: a1, data: d1});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; inValid = '0; inAddr = '0; inData = '0; outReady = '0;
    rrModel = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("por");
    cmp("por.ain", 64'(ain), 64'(0));
    cmp("por.din0", din[0], 64'(0));

    // No conflict: different destinations go out together.
    applyStimulus(2'b11, 5'b00000, 5'b00001, 64'hA0, 64'hB1, 2'b11, "t2.push");
    applyStimulus(2'b00, 5'b00000, 5'b00000, 64'h0, 64'h0, 2'b11, "t2.both");
    cmp("t2.dst0", 64'(ain[0][BITID]), 64'(0));
    applyStimulus(2'b00, 5'b00000, 5'b00000, 64'h0, 64'h0, 2'b11, "t2.empty");

    // Conflict: port 0 wins first, then port 1.
    applyStimulus(2'b11, 5'b00011, 5'b10001, 64'hC0, 64'hC1, 2'b11, "t3.push");
    applyStimulus(2'b00, 5'b00000, 5'b00000, 64'h0, 64'h0, 2'b11, "t3.c1");
    applyStimulus(2'b00, 5'b00000, 5'b00000, 64'h0, 64'h0, 2'b11, "t3.c2");
    applyStimulus(2'b00, 5'b00000, 5'b00000, 64'h0, 64'h0, 2'b11, "t3.empty");

    // Fairness: both FIFOs full toward output 0, drained alternately.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(2'b11, NA'(2 * i), NA'(2 * i + 4), 64'(16 + i), 64'(32 + i), 2'b00, "t4.fill");
    for (int i = 0; i < 2 * DEPTH; i++)
      applyStimulus(2'b00, 5'b0, 5'b0, 64'h0, 64'h0, 2'b01, "t4.drain");
    applyStimulus(2'b00, 5'b0, 5'b0, 64'h0, 64'h0, 2'b01, "t4.empty");

    // Backpressure: a fifth push into a full FIFO is refused.
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(2'b01, NA'(i), 5'b0, 64'(64'h500 + i), 64'h0, 2'b00, "t5.push");
    cmp("t5.full", 64'(inReady[0]), 64'(0));
    for (int i = 0; i < 2; i++)
      applyStimulus(2'b00, 5'b0, 5'b0, 64'h0, 64'h0, 2'b00, "t5.hold");
    cmp("t5.headStable", din[0], 64'h500);
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(2'b00, 5'b0, 5'b0, 64'h0, 64'h0, 2'b11, "t5.drain");

    // Wrap: ten packets streamed through port 1 in order.
    logT6 = 1'b1;
    for (int i = 0; i < 10; i++)
      applyStimulus(2'b10, 5'b0, NA'($urandom), 64'h0, 64'(i), 2'b11, "t6.stream");
    for (int i = 0; i < 2; i++)
      applyStimulus(2'b00, 5'b0, 5'b0, 64'h0, 64'h0, 2'b11, "t6.drain");
    logT6 = 1'b0;
    cmp("t6.count", 64'(t6Log.size()), 64'(10));
    for (int i = 0; i < t6Log.size(); i++) cmp("t6.order", t6Log[i], 64'(i));

    // Reset mid-traffic: three queued entries disappear, priority reverts.
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b01, NA'(i), 5'b0, 64'(64'h700 + i), 64'h0, 2'b00, "t1.fill");
    rst = 1'b1;
    #1;
    cmp("t1.din_valid", 64'(dinValid), 64'(0));
    cmp("t1.in_ready", 64'(inReady), 64'(3));
    cmp("t1.ain", 64'(ain), 64'(0));
    cmp("t1.din1", din[1], 64'(0));
    q0.delete(); q1.delete(); rrModel = 1'b0;
    #1 rst = 1'b0;
    applyStimulus(2'b11, 5'b00101, 5'b00111, 64'h900, 64'h901, 2'b00, "t1.push");
    cmp("t1.latency", 64'(dinValid), 64'(1));
    applyStimulus(2'b00, 5'b0, 5'b0, 64'h0, 64'h0, 2'b11, "t1.win0");
    applyStimulus(2'b00, 5'b0, 5'b0, 64'h0, 64'h0, 2'b11, "t1.win1");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      applyStimulus(2'($urandom), NA'($urandom), NA'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    2'($urandom), "rand");
    for (int i = 0; i < 2 * DEPTH + 2; i++)
      applyStimulus(2'b00, 5'b0, 5'b0, 64'h0, 64'h0, 2'b11, "rand.drain");
    checkOutput("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
